// File: rtl/load_store_unit.sv
// Load/store sequencer: accepts one memory request at a time, checks alignment,
// drives a word-addressed data memory with byte-lane strobes, and returns
// extended load data (or an error flag) on a valid/ready response channel.
module load_store_unit #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [3:0]            mem_be,
  output logic                  mem_re,
  output logic                  mem_we,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // WAIT lasts MEM_LAT cycles; the counter is loaded with MEM_LAT-1 on entry.
  localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

  state_t                state_q, state_d;
  logic [DM_ADDRESS-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic                  mem_re_q, mem_re_d;
  logic                  mem_we_q, mem_we_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  is_load_q, is_load_d;
  logic [1:0]            cnt_q, cnt_d;

  logic                  req_err;
  logic [3:0]            st_be;
  logic [DATA_W-1:0]     st_wdata;
  logic [DATA_W-1:0]     ld_shift;
  logic [DATA_W-1:0]     ld_data;

  assign req_ready = (state_q == IDLE);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Request legality: conflicting direction, unsupported width code, or misalignment.
  always_comb begin
    logic f3_load_ok;
    logic f3_store_ok;
    logic misaligned;
    f3_load_ok  = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                  (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                  (req_funct3 == 3'b101);
    f3_store_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                  (req_funct3 == 3'b010);
    misaligned  = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                  ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_err     = (req_read && req_write) ||
                  (req_read && !f3_load_ok) ||
                  (req_write && !f3_store_ok) ||
                  misaligned;
  end

  // Store lane steering: byte/halfword data is replicated across all lanes and
  // the byte enables select the lanes that actually get written.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << req_addr[1:0];
        st_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = req_wdata;
      end
    endcase
  end

  // Load extraction: bring the addressed byte/halfword down to bit 0, then extend.
  always_comb begin
    ld_shift = mem_rdata >> {addr_lo_q, 3'b000};
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_data = {24'd0, ld_shift[7:0]};
      3'b101:  ld_data = {16'd0, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  // Next-state and registered-output logic; strobes default low every cycle.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = 4'b0000;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    addr_lo_d   = addr_lo_q;
    funct3_d    = funct3_q;
    is_load_d   = is_load_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        // A request with neither direction set is consumed without a response.
        if (req_valid && (req_read || req_write)) begin
          addr_lo_d = req_addr[1:0];
          funct3_d  = req_funct3;
          is_load_d = req_read;
          if (req_err) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d    = ISSUE;
            mem_addr_d = {req_addr[DM_ADDRESS-1:2], 2'b00};
            if (req_read) begin
              mem_re_d = 1'b1;
            end else begin
              mem_we_d    = 1'b1;
              mem_be_d    = st_be;
              mem_wdata_d = st_wdata;
            end
          end
        end
      end
      ISSUE: begin
        if (is_load_q) begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = ld_data;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= 4'b0000;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      addr_lo_q   <= 2'b00;
      funct3_q    <= 3'b000;
      is_load_q   <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      addr_lo_q   <= addr_lo_d;
      funct3_q    <= funct3_d;
      is_load_q   <= is_load_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: lane 0 runs with MEM_LAT=1, lane 1 with MEM_LAT=3. Each lane
// has a small byte-enabled memory with a registered, latency-delayed read port
// that returns garbage outside the valid read cycle.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_read;
  logic        req_write;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic [8:0]  mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_be    [2];
  logic        mem_re    [2];
  logic        mem_we    [2];
  logic [31:0] mem_rdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int tests_run = 0;
  int tests_failed = 0;

  // Snapshot of the memory port taken in the cycle after acceptance.
  logic [8:0]  iss_addr;
  logic [3:0]  iss_be;
  logic [31:0] iss_wdata;
  logic        iss_re;
  logic        iss_we;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    localparam int LAT = (gi == 0) ? 1 : 3;
    logic [31:0] mem [128];
    logic [31:0] pipe_d [3];
    logic [2:0]  pipe_v = 3'b000;
    int re_cnt = 0;
    int we_cnt = 0;

    load_store_unit #(.DM_ADDRESS(9), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid[gi]),
      .req_ready  (req_ready[gi]),
      .req_read   (req_read),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_funct3 (req_funct3),
      .mem_addr   (mem_addr[gi]),
      .mem_wdata  (mem_wdata[gi]),
      .mem_be     (mem_be[gi]),
      .mem_re     (mem_re[gi]),
      .mem_we     (mem_we[gi]),
      .mem_rdata  (mem_rdata[gi]),
      .rsp_valid  (rsp_valid[gi]),
      .rsp_ready  (rsp_ready[gi]),
      .rsp_rdata  (rsp_rdata[gi]),
      .rsp_err    (rsp_err[gi])
    );

    always @(posedge clk) begin
      if (mem_we[gi]) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[gi][b]) mem[mem_addr[gi][8:2]][8*b +: 8] <= mem_wdata[gi][8*b +: 8];
        end
      end
      pipe_v    <= {pipe_v[1:0], mem_re[gi]};
      pipe_d[0] <= mem[mem_addr[gi][8:2]];
      pipe_d[1] <= pipe_d[0];
      pipe_d[2] <= pipe_d[1];
      if (mem_re[gi]) re_cnt <= re_cnt + 1;
      if (mem_we[gi]) we_cnt <= we_cnt + 1;
    end

    assign mem_rdata[gi] = pipe_v[LAT-1] ? pipe_d[LAT-1] : 32'hDEADBEEF;
  end

  function automatic int re_count(input int k);
    if (k == 0) return g_lane[0].re_cnt;
    else return g_lane[1].re_cnt;
  endfunction

  function automatic int we_count(input int k);
    if (k == 0) return g_lane[0].we_cnt;
    else return g_lane[1].we_cnt;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full request/response exchange on lane k, with optional response stall.
  // While stalled, a competing store request is held on req_valid; it must not be taken.
  task automatic xact(input int k, input string tag, input logic rd, input logic wr,
                      input logic [2:0] f3, input logic [8:0] addr, input logic [31:0] wd,
                      input int stall, input int exp_lat, input logic exp_err,
                      input logic [31:0] exp_rdata);
    int n;
    int re0;
    int we0;
    logic exp_re;
    logic exp_we;
    exp_re = rd && !wr && !exp_err;
    exp_we = wr && !rd && !exp_err;
    re0 = re_count(k);
    we0 = we_count(k);
    check_eq({tag, ".ready_idle"}, 32'(req_ready[k]), 32'd1);
    req_read     = rd;
    req_write    = wr;
    req_funct3   = f3;
    req_addr     = addr;
    req_wdata    = wd;
    req_valid[k] = 1'b1;
    rsp_ready[k] = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    req_valid[k] = 1'b0;
    n = 1;
    iss_addr  = mem_addr[k];
    iss_be    = mem_be[k];
    iss_wdata = mem_wdata[k];
    iss_re    = mem_re[k];
    iss_we    = mem_we[k];
    check_eq({tag, ".ready_busy"}, 32'(req_ready[k]), 32'd0);
    check_eq({tag, ".issue_re"}, 32'(iss_re), 32'(exp_re));
    check_eq({tag, ".issue_we"}, 32'(iss_we), 32'(exp_we));
    while (!rsp_valid[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, ".latency"}, n, exp_lat);
    check_eq({tag, ".err"}, 32'(rsp_err[k]), 32'(exp_err));
    check_eq({tag, ".rdata"}, rsp_rdata[k], exp_rdata);
    for (int s = 0; s < stall; s++) begin
      check_eq({tag, ".stall_valid"}, 32'(rsp_valid[k]), 32'd1);
      check_eq({tag, ".stall_rdata"}, rsp_rdata[k], exp_rdata);
      check_eq({tag, ".stall_ready"}, 32'(req_ready[k]), 32'd0);
      req_read     = 1'b0;
      req_write    = 1'b1;
      req_funct3   = 3'b010;
      req_addr     = 9'h014;
      req_wdata    = 32'h55555555;
      req_valid[k] = 1'b1;
      @(negedge clk);
    end
    req_valid[k] = 1'b0;
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    check_eq({tag, ".done_valid"}, 32'(rsp_valid[k]), 32'd0);
    check_eq({tag, ".done_ready"}, 32'(req_ready[k]), 32'd1);
    check_eq({tag, ".done_rdata"}, rsp_rdata[k], 32'd0);
    check_eq({tag, ".re_pulses"}, re_count(k) - re0, 32'(exp_re));
    check_eq({tag, ".we_pulses"}, we_count(k) - we0, 32'(exp_we));
    $display("[TB] %s lane=%0d addr=0x%03h lat=%0d err=%0b rdata=0x%08h", tag, k, addr, n,
             rsp_err[k], exp_rdata);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int re0;
    int we0;
    reset        = 1'b0;
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    rsp_ready[0] = 1'b1;
    rsp_ready[1] = 1'b1;
    req_read     = 1'b0;
    req_write    = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    req_funct3   = '0;
    repeat (3) @(negedge clk);

    // Reset state
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("rst%0d.req_ready", k), 32'(req_ready[k]), 32'd1);
      check_eq($sformatf("rst%0d.rsp_valid", k), 32'(rsp_valid[k]), 32'd0);
      check_eq($sformatf("rst%0d.mem_re", k), 32'(mem_re[k]), 32'd0);
      check_eq($sformatf("rst%0d.mem_we", k), 32'(mem_we[k]), 32'd0);
      check_eq($sformatf("rst%0d.mem_be", k), 32'(mem_be[k]), 32'd0);
      check_eq($sformatf("rst%0d.mem_addr", k), 32'(mem_addr[k]), 32'd0);
      check_eq($sformatf("rst%0d.rsp_rdata", k), rsp_rdata[k], 32'd0);
    end
    $display("[TB] reset released");
    reset = 1'b1;
    @(negedge clk);

    // Stores and loads on the MEM_LAT=1 lane
    xact(0, "SB_0D", 0, 1, 3'b000, 9'h00D, 32'h000000A5, 0, 2, 0, 32'h0);
    check_eq("SB_0D.mem_addr", 32'(iss_addr), 32'h00C);
    check_eq("SB_0D.mem_be", 32'(iss_be), 32'b0010);
    check_eq("SB_0D.mem_wdata", iss_wdata, 32'hA5A5A5A5);
    xact(0, "SW_0C", 0, 1, 3'b010, 9'h00C, 32'h12F03456, 0, 2, 0, 32'h0);
    check_eq("SW_0C.mem_be", 32'(iss_be), 32'b1111);
    check_eq("SW_0C.mem_wdata", iss_wdata, 32'h12F03456);
    xact(0, "LB_0E", 1, 0, 3'b000, 9'h00E, 32'h0, 0, 3, 0, 32'hFFFFFFF0);
    check_eq("LB_0E.mem_addr", 32'(iss_addr), 32'h00C);
    check_eq("LB_0E.mem_be", 32'(iss_be), 32'b0000);
    xact(0, "LBU_0E", 1, 0, 3'b100, 9'h00E, 32'h0, 0, 3, 0, 32'h000000F0);
    xact(0, "LHU_0E", 1, 0, 3'b101, 9'h00E, 32'h0, 0, 3, 0, 32'h000012F0);
    xact(0, "LB_0D", 1, 0, 3'b000, 9'h00D, 32'h0, 0, 3, 0, 32'h00000034);
    xact(0, "LW_0C", 1, 0, 3'b010, 9'h00C, 32'h0, 0, 3, 0, 32'h12F03456);
    xact(0, "SH_02", 0, 1, 3'b001, 9'h002, 32'h1234BEEF, 0, 2, 0, 32'h0);
    check_eq("SH_02.mem_be", 32'(iss_be), 32'b1100);
    check_eq("SH_02.mem_wdata", iss_wdata, 32'hBEEFBEEF);
    xact(0, "LH_02", 1, 0, 3'b001, 9'h002, 32'h0, 0, 3, 0, 32'hFFFFBEEF);
    xact(0, "LHU_02", 1, 0, 3'b101, 9'h002, 32'h0, 0, 3, 0, 32'h0000BEEF);
    xact(0, "SB_0F", 0, 1, 3'b000, 9'h00F, 32'h00000080, 0, 2, 0, 32'h0);
    check_eq("SB_0F.mem_be", 32'(iss_be), 32'b1000);
    xact(0, "LB_0F", 1, 0, 3'b000, 9'h00F, 32'h0, 0, 3, 0, 32'hFFFFFF80);
    xact(0, "LW_0C_b", 1, 0, 3'b010, 9'h00C, 32'h0, 0, 3, 0, 32'h80F03456);

    // Error responses: one cycle, no strobes
    xact(0, "ERR_LW_06", 1, 0, 3'b010, 9'h006, 32'h0, 0, 1, 1, 32'h0);
    xact(0, "ERR_SH_03", 0, 1, 3'b001, 9'h003, 32'hFFFFFFFF, 0, 1, 1, 32'h0);
    xact(0, "ERR_RW", 1, 1, 3'b010, 9'h000, 32'h0, 0, 1, 1, 32'h0);
    xact(0, "ERR_ST_F3_100", 0, 1, 3'b100, 9'h000, 32'h0, 0, 1, 1, 32'h0);
    xact(0, "ERR_LD_F3_011", 1, 0, 3'b011, 9'h000, 32'h0, 0, 1, 1, 32'h0);
    xact(0, "ERR_LH_0D", 1, 0, 3'b001, 9'h00D, 32'h0, 0, 1, 1, 32'h0);

    // Neither read nor write: consumed silently
    re0 = re_count(0);
    we0 = we_count(0);
    req_read     = 1'b0;
    req_write    = 1'b0;
    req_funct3   = 3'b010;
    req_addr     = 9'h000;
    req_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_eq("NOP.req_ready", 32'(req_ready[0]), 32'd1);
      check_eq("NOP.rsp_valid", 32'(rsp_valid[0]), 32'd0);
      @(negedge clk);
    end
    check_eq("NOP.re_pulses", re_count(0) - re0, 32'd0);
    check_eq("NOP.we_pulses", we_count(0) - we0, 32'd0);
    $display("[TB] NOP lane=0 no response");

    // MEM_LAT=3 lane: load with a 4-cycle response stall
    xact(1, "SW_10", 0, 1, 3'b010, 9'h010, 32'hCAFEF00D, 0, 2, 0, 32'h0);
    xact(1, "LW_10_stall", 1, 0, 3'b010, 9'h010, 32'h0, 4, 5, 0, 32'hCAFEF00D);

    // Reset asserted mid-WAIT on the MEM_LAT=3 lane
    check_eq("RSTW.ready_idle", 32'(req_ready[1]), 32'd1);
    req_read     = 1'b1;
    req_write    = 1'b0;
    req_funct3   = 3'b010;
    req_addr     = 9'h010;
    req_valid[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    check_eq("RSTW.issue_re", 32'(mem_re[1]), 32'd1);
    @(negedge clk);
    check_eq("RSTW.wait_re", 32'(mem_re[1]), 32'd0);
    check_eq("RSTW.wait_addr", 32'(mem_addr[1]), 32'h010);
    check_eq("RSTW.wait_ready", 32'(req_ready[1]), 32'd0);
    #2 reset = 1'b0;
    #1;
    check_eq("RSTW.mem_re", 32'(mem_re[1]), 32'd0);
    check_eq("RSTW.rsp_valid", 32'(rsp_valid[1]), 32'd0);
    check_eq("RSTW.req_ready", 32'(req_ready[1]), 32'd1);
    check_eq("RSTW.mem_addr", 32'(mem_addr[1]), 32'h000);
    @(negedge clk);
    check_eq("RSTW.held_valid", 32'(rsp_valid[1]), 32'd0);
    reset = 1'b1;
    $display("[TB] RST_MID_WAIT lane=1 access abandoned");
    @(negedge clk);
    xact(1, "LW_10_after_rst", 1, 0, 3'b010, 9'h010, 32'h0, 0, 5, 0, 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
